// File: rtl/countdown_multi_if.sv
// rtl/countdown_multi_if.sv - control/status bundle for the multi-channel countdown timer
interface countdown_multi_if #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_BITS = 8
);
    logic                           tick;
    logic                           enable;
    logic [CHANNELS-1:0]            start;
    logic [CHANNELS-1:0]            abort;
    logic [CHANNELS-1:0]            hold;
    logic [CHANNELS-1:0]            reload_mode;
    logic [CHANNELS*COUNT_BITS-1:0] count_from;
    logic [CHANNELS*COUNT_BITS-1:0] current_count;
    logic [CHANNELS-1:0]            running;
    logic [CHANNELS-1:0]            timeout;
    logic [CHANNELS-1:0]            expired;

    modport master (
        output tick, enable, start, abort, hold, reload_mode, count_from,
        input  current_count, running, timeout, expired
    );

    modport slave (
        input  tick, enable, start, abort, hold, reload_mode, count_from,
        output current_count, running, timeout, expired
    );
endinterface

// File: rtl/countdown_multi.sv
// rtl/countdown_multi.sv - CHANNELS independent down-counters sharing one tick strobe
module countdown_multi #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    countdown_multi_if.slave bus
);
    localparam logic [COUNT_BITS-1:0] ONE = COUNT_BITS'(1);

    logic [CHANNELS-1:0][COUNT_BITS-1:0] count_w;
    logic [CHANNELS-1:0]                 running_w;
    logic [CHANNELS-1:0]                 timeout_w;
    logic [CHANNELS-1:0]                 expired_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

        state_t                state_q;
        logic [COUNT_BITS-1:0] count_q;
        logic                  running_q;
        logic                  timeout_q;
        logic                  expired_q;
        logic [COUNT_BITS-1:0] load_d;
        logic                  dec_d;

        assign load_d = bus.count_from[i*COUNT_BITS +: COUNT_BITS];
        assign dec_d  = bus.tick & bus.enable & ~bus.hold[i];

        // abort beats start beats the tick; a zero load expires at once
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= S_IDLE;
                count_q   <= '0;
                running_q <= 1'b0;
                timeout_q <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                timeout_q <= 1'b0;
                if (bus.abort[i]) begin
                    state_q   <= S_IDLE;
                    count_q   <= '0;
                    running_q <= 1'b0;
                    expired_q <= 1'b0;
                end else if (bus.start[i]) begin
                    count_q <= load_d;
                    if (load_d != '0) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                        expired_q <= 1'b0;
                    end else begin
                        state_q   <= S_DONE;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                        expired_q <= 1'b1;
                    end
                end else if (state_q == S_RUN && dec_d) begin
                    if (count_q > ONE) begin
                        count_q <= count_q - ONE;
                    end else if (bus.reload_mode[i] && load_d != '0) begin
                        count_q   <= load_d;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q   <= S_DONE;
                        count_q   <= '0;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                        expired_q <= 1'b1;
                    end
                end
            end
        end

        assign count_w[i]   = count_q;
        assign running_w[i] = running_q;
        assign timeout_w[i] = timeout_q;
        assign expired_w[i] = expired_q;
    end

    assign bus.current_count = count_w;
    assign bus.running       = running_w;
    assign bus.timeout       = timeout_w;
    assign bus.expired       = expired_w;
endmodule

// File: tb/tb_countdown_multi.sv
// tb/tb_countdown_multi.sv - directed scoreboard bench for countdown_multi
module tb_countdown_multi;
    localparam int CH = 4;
    localparam int CB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    countdown_multi_if #(.CHANNELS(CH), .COUNT_BITS(CB)) bus ();

    countdown_multi #(.CHANNELS(CH), .COUNT_BITS(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    string       tag_q[$];
    logic [31:0] val_q[$];
    int          passed = 0;
    int          total  = 0;

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] expv;
        total++;
        if (tag_q.size() == 0) begin
            tag  = "empty_scoreboard";
            expv = 32'hxxxx_xxxx;
        end else begin
            tag  = tag_q.pop_front();
            expv = val_q.pop_front();
        end
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(bus.current_count[ch*CB +: CB]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_from(input int ch, input logic [CB-1:0] v);
        bus.count_from[ch*CB +: CB] = v;
    endtask

    task automatic start_ch(input int ch);
        bus.start[ch] = 1'b1;
        cyc();
        bus.start = '0;
    endtask

    task automatic tick_edge();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    initial begin
        bus.tick = 0; bus.enable = 1; bus.start = '0; bus.abort = '0;
        bus.hold = '0; bus.reload_mode = '0; bus.count_from = '0;

        // reset
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        push("rst_count", 0); push("rst_running", 0); push("rst_timeout", 0); push("rst_expired", 0);
        chk(32'(bus.current_count)); chk(32'(bus.running)); chk(32'(bus.timeout)); chk(32'(bus.expired));

        // one-shot ch0 from 10
        set_from(0, 8'd10);
        push("os_load", 10); push("os_run", 4'b0001);
        start_ch(0);
        chk(cnt(0)); chk(32'(bus.running));
        for (int k = 1; k <= 10; k++) begin
            push($sformatf("os_cnt_t%0d", k), 32'(10 - k));
            push($sformatf("os_to_t%0d", k), (k == 10) ? 32'b0001 : 32'b0);
            tick_edge();
            chk(cnt(0)); chk(32'(bus.timeout));
            cyc();
        end
        push("os_to_gone", 0); push("os_expired", 4'b0001); push("os_running", 0); push("os_others", 0);
        chk(32'(bus.timeout)); chk(32'(bus.expired)); chk(32'(bus.running));
        chk(32'(bus.current_count[CH*CB-1:CB]));

        // auto-reload ch1 from 3
        set_from(1, 8'd3);
        bus.reload_mode[1] = 1'b1;
        start_ch(1);
        for (int t = 1; t <= 10; t++) begin
            push($sformatf("ar_cnt_t%0d", t), (t % 3 == 0) ? 32'd3 : 32'(3 - (t % 3)));
            push($sformatf("ar_to_t%0d", t), (t % 3 == 0) ? 32'b0010 : 32'b0);
            tick_edge();
            chk(cnt(1)); chk(32'(bus.timeout));
            cyc();
        end
        push("ar_expired", 4'b0001); push("ar_running", 4'b0010);
        chk(32'(bus.expired)); chk(32'(bus.running));
        bus.abort[1] = 1'b1; cyc(); bus.abort = '0;
        push("ab1_count", 0); push("ab1_running", 0);
        chk(cnt(1)); chk(32'(bus.running));

        // hold / enable: ch2 from 5, ch3 from 20 alongside
        bus.reload_mode = '0;
        set_from(2, 8'd5); set_from(3, 8'd20);
        bus.start = 4'b1100; cyc(); bus.start = '0;
        for (int t = 1; t <= 8; t++) begin
            bus.hold[2] = (t <= 2);
            bus.enable  = (t != 3);
            push($sformatf("he_c2_t%0d", t), (t <= 3) ? 32'd5 : 32'(8 - t));
            push($sformatf("he_c3_t%0d", t), 32'(20 - t + ((t >= 3) ? 1 : 0)));
            push($sformatf("he_to_t%0d", t), (t == 8) ? 32'b0100 : 32'b0);
            tick_edge();
            bus.hold = '0; bus.enable = 1'b1;
            chk(cnt(2)); chk(cnt(3)); chk(32'(bus.timeout));
            cyc();
        end
        push("he_expired", 4'b0101);
        chk(32'(bus.expired));
        bus.abort[3] = 1'b1; cyc(); bus.abort = '0;

        // start coincident with tick: load wins
        set_from(0, 8'd7);
        start_ch(0);
        set_from(0, 8'd9);
        bus.start[0] = 1'b1; bus.tick = 1'b1;
        push("pr_start_tick", 9); push("pr_exp_clr", 4'b0100);
        cyc(); bus.start = '0; bus.tick = 1'b0;
        chk(cnt(0)); chk(32'(bus.expired));

        // abort on the expiring tick of ch1
        set_from(1, 8'd1);
        start_ch(1);
        bus.abort[1] = 1'b1;
        push("pr_ab_to", 0); push("pr_ab_cnt", 0); push("pr_ab_run", 4'b0001); push("pr_ab_ch0", 8);
        tick_edge(); bus.abort = '0;
        chk(32'(bus.timeout)); chk(cnt(1)); chk(32'(bus.running)); chk(cnt(0));

        // zero load expires immediately, even in reload mode
        bus.abort[2] = 1'b1; cyc(); bus.abort = '0;
        push("pr_ab2_exp", 0);
        chk(32'(bus.expired));
        set_from(2, 8'd0); bus.reload_mode[2] = 1'b1;
        push("z_to", 4'b0100); push("z_exp", 4'b0100); push("z_run", 4'b0001); push("z_to_gone", 0);
        start_ch(2);
        chk(32'(bus.timeout)); chk(32'(bus.expired)); chk(32'(bus.running));
        cyc();
        chk(32'(bus.timeout));
        bus.abort[0] = 1'b1; cyc(); bus.abort = '0;

        // mid-run count_from change in reload mode on ch3
        set_from(3, 8'd10); bus.reload_mode[3] = 1'b1;
        start_ch(3);
        set_from(3, 8'd20);
        for (int t = 1; t <= 11; t++) begin
            push($sformatf("mr_cnt_t%0d", t), (t < 10) ? 32'(10 - t) : (t == 10) ? 32'd20 : 32'd19);
            push($sformatf("mr_to_t%0d", t), (t == 10) ? 32'd1 : 32'd0);
            tick_edge();
            chk(cnt(3)); chk(32'(bus.timeout[3]));
            cyc();
        end

        // asynchronous reset mid-run
        #3 rst_n = 1'b0;
        #1;
        push("ar_count", 0); push("ar_running", 0); push("ar_timeout", 0); push("ar_expired", 0);
        chk(32'(bus.current_count)); chk(32'(bus.running)); chk(32'(bus.timeout)); chk(32'(bus.expired));
        cyc();
        rst_n = 1'b1;
        cyc();
        set_from(0, 8'd2);
        push("resume_cnt", 2); push("resume_run", 4'b0001);
        start_ch(0);
        chk(cnt(0)); chk(32'(bus.running));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
